sync_ram_init_sc: RTL and testbench



---
 rtl/sync_ram_pkg.sv | 20 ++
 rtl/sync_ram_core_be.sv | 38 +++
 rtl/sync_ram_init_sc.sv | 147 ++++++++++++++
 tb/tb_sync_ram_init_sc.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the single-clock initialising RAM.
// Holds the clear-FSM state encoding, the read-during-write mode codes and the byte merge helper.
package sync_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Picks the new byte when its enable is set, otherwise keeps the old byte.
    function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/sync_ram_core_be.sv
// Bare storage array with per-byte write enables and a registered read port.
// A read and a write to the same address on the same edge return the word from before the write.
module sync_ram_core_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it can map onto block RAM; the clear engine defines its contents.
    // NOTE: non-blocking writes let a same-edge read sample the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_ram_init_sc.sv
// Simple-dual-port RAM with byte enables, selectable read latency and read-during-write mode.
// A clear engine fills every word with INIT_VALUE after reset or on init_req.
module sync_ram_init_sc
    import sync_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RD_LATENCY = 1,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wren,
    input  logic [ADDR_WIDTH-1:0]   wraddr,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    rden,
    input  logic [ADDR_WIDTH-1:0]   rdaddr,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    q_valid,
    input  logic                    init_req,
    output logic                    init_busy,
    output logic                    init_done
);

    localparam int NB = DATA_WIDTH / 8;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic                    clearing, rd_accept, wr_accept;
    logic                    core_we;
    logic [ADDR_WIDTH-1:0]   core_waddr;
    logic [DATA_WIDTH-1:0]   core_wdata, core_q, merged;
    logic [NB-1:0]           core_wbe;
    logic                    v1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // NOTE: defaults first keep this block free of inferred latches.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) state_d = ST_READY;
            end
            ST_READY: begin
                if (init_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign clearing  = (state_q == ST_CLEAR);
    assign rd_accept = rden && !clearing;
    assign wr_accept = wren && !clearing;
    assign init_busy = clearing;
    assign init_done = !clearing;

    // The clear engine owns the write port for the whole sweep.
    assign core_we    = clearing || wr_accept;
    assign core_waddr = clearing ? clr_addr_q : wraddr;
    assign core_wdata = clearing ? INIT_VALUE : data;
    assign core_wbe   = clearing ? '1 : be;

    sync_ram_core_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .wbe   (core_wbe),
        .re    (rd_accept),
        .raddr (rdaddr),
        .rdata (core_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) v1 <= 1'b0;
        else        v1 <= rd_accept;
    end

    generate
        if (RDW_MODE == RDW_NEW) begin : g_bypass
            logic [DATA_WIDTH-1:0] byp_data;
            logic [NB-1:0]         byp_be;

            // Only a colliding write leaves non-zero enables to patch into the old word.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    byp_data <= '0;
                    byp_be   <= '0;
                end else if (rd_accept) begin
                    byp_data <= data;
                    byp_be   <= (wr_accept && (wraddr == rdaddr)) ? be : '0;
                end
            end

            always_comb begin
                merged = core_q;
                for (int i = 0; i < NB; i++) begin
                    merged[8*i +: 8] = be_merge(core_q[8*i +: 8], byp_data[8*i +: 8], byp_be[i]);
                end
            end
        end else begin : g_no_bypass
            assign merged = core_q;
        end

        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] q2;
            logic                  v2;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) q2 <= merged;
                end
            end

            assign q       = q2;
            assign q_valid = v2;
        end else begin : g_lat1
            assign q       = merged;
            assign q_valid = v1;
        end
    endgenerate

endmodule

// File: tb/tb_sync_ram_init_sc.sv
// Directed bench for sync_ram_init_sc: instance a is latency 1 / old-data,
// instance b is latency 2 / new-data with a non-zero clear value; both see identical stimulus.
module tb_sync_ram_init_sc;

    localparam logic [31:0] INIT_A = 32'h0000_0000;
    localparam logic [31:0] INIT_B = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wren, rden, init_req;
    logic [7:0]  wraddr, rdaddr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] qa, qb;
    logic        qva, qvb, busya, busyb, donea, doneb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_ram_init_sc #(
        .DATA_WIDTH (32), .ADDR_WIDTH (8), .RD_LATENCY (1), .RDW_MODE (0), .INIT_VALUE (INIT_A)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .wren (wren), .wraddr (wraddr), .data (data), .be (be),
        .rden (rden), .rdaddr (rdaddr), .q (qa), .q_valid (qva),
        .init_req (init_req), .init_busy (busya), .init_done (donea)
    );

    sync_ram_init_sc #(
        .DATA_WIDTH (32), .ADDR_WIDTH (8), .RD_LATENCY (2), .RDW_MODE (1), .INIT_VALUE (INIT_B)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .wren (wren), .wraddr (wraddr), .data (data), .be (be),
        .rden (rden), .rdaddr (rdaddr), .q (qb), .q_valid (qvb),
        .init_req (init_req), .init_busy (busyb), .init_done (doneb)
    );

    task automatic do_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        wren = 1'b1; wraddr = addr; data = d; be = b;
        @(negedge clk);
        wren = 1'b0;
    endtask

    // Single read: a answers one edge after rden, b one edge later; a must then hold q.
    task automatic do_read(input logic [7:0] addr, input logic [31:0] exp_a,
                           input logic [31:0] exp_b, input string name);
        @(negedge clk);
        rden = 1'b1; rdaddr = addr;
        @(posedge clk); #1;
        checks++;
        if (qva !== 1'b1 || qa !== exp_a) begin
            failures++;
            $display("FAIL %s lat1: q=%h q_valid=%b, expected q=%h q_valid=1", name, qa, qva, exp_a);
        end
        checks++;
        if (qvb !== 1'b0) begin
            failures++;
            $display("FAIL %s lat2 early: q_valid=%b, expected 0", name, qvb);
        end
        @(negedge clk);
        rden = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (qvb !== 1'b1 || qb !== exp_b) begin
            failures++;
            $display("FAIL %s lat2: q=%h q_valid=%b, expected q=%h q_valid=1", name, qb, qvb, exp_b);
        end
        checks++;
        if (qva !== 1'b0 || qa !== exp_a) begin
            failures++;
            $display("FAIL %s lat1 hold: q=%h q_valid=%b, expected q=%h q_valid=0", name, qa, qva, exp_a);
        end
    endtask

    // Counts edges after rst_n release until init_busy falls (bounded).
    task automatic count_clear(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busya && n < 1000);
        checks++;
        if (n != 256 || busyb !== 1'b0 || donea !== 1'b1 || doneb !== 1'b1) begin
            failures++;
            $display("FAIL %s: busy cycles=%0d busy_b=%b done=%b/%b, expected 256 cycles then done=1/1",
                     name, n, busyb, donea, doneb);
        end
    endtask

    task automatic check_in_reset(input string name);
        checks++;
        if (qa !== 32'h0 || qva !== 1'b0 || qb !== 32'h0 || qvb !== 1'b0 ||
            busya !== 1'b1 || busyb !== 1'b1 || donea !== 1'b0 || doneb !== 1'b0) begin
            failures++;
            $display("FAIL %s: qa=%h qva=%b qb=%h qvb=%b busy=%b/%b done=%b/%b, expected zeros, busy=1 done=0",
                     name, qa, qva, qb, qvb, busya, busyb, donea, doneb);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wren = 1'b0; rden = 1'b0; init_req = 1'b0;
        wraddr = '0; rdaddr = '0; data = '0; be = '0;
        repeat (3) @(posedge clk);
        #1;
        check_in_reset("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        count_clear("reset_bringup");
        do_read(8'h00, INIT_A, INIT_B, "init_rd_00");
        do_read(8'h7F, INIT_A, INIT_B, "init_rd_7f");
        do_read(8'hFF, INIT_A, INIT_B, "init_rd_ff");
    endtask

    task automatic test_byte_enables();
        do_write(8'h10, 32'hAABB_CCDD, 4'hF);
        do_write(8'h10, 32'h1122_3344, 4'b0101);
        do_write(8'h10, 32'hFFFF_FFFF, 4'b0000);
        do_read(8'h10, 32'hAA22_CC44, 32'hAA22_CC44, "byte_enables");
    endtask

    task automatic test_collision();
        do_write(8'h20, 32'h1234_5678, 4'hF);
        @(negedge clk);
        wren = 1'b1; wraddr = 8'h20; data = 32'hCAFE_BABE; be = 4'b0011;
        rden = 1'b1; rdaddr = 8'h20;
        @(posedge clk); #1;
        checks++;
        if (qva !== 1'b1 || qa !== 32'h1234_5678) begin
            failures++;
            $display("FAIL collision_old: q=%h q_valid=%b, expected q=12345678 q_valid=1", qa, qva);
        end
        @(negedge clk);
        wren = 1'b0; rden = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (qvb !== 1'b1 || qb !== 32'h1234_BABE) begin
            failures++;
            $display("FAIL collision_new: q=%h q_valid=%b, expected q=1234babe q_valid=1", qb, qvb);
        end
        do_read(8'h20, 32'h1234_BABE, 32'h1234_BABE, "after_collision");
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals = '{32'h3000_0001, 32'h3111_0002, 32'h3222_0003, 32'h3333_0004};
        for (int i = 0; i < 4; i++) do_write(8'h30 + 8'(i), vals[i], 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rden   = (i < 4);
            rdaddr = 8'h30 + 8'(i % 4);
            @(posedge clk); #1;
            checks++;
            if (i < 4) begin
                if (qva !== 1'b1 || qa !== vals[i]) begin
                    failures++;
                    $display("FAIL b2b_lat1[%0d]: q=%h q_valid=%b, expected q=%h q_valid=1", i, qa, qva, vals[i]);
                end
            end else if (qva !== 1'b0) begin
                failures++;
                $display("FAIL b2b_lat1_end: q_valid=%b, expected 0", qva);
            end
            checks++;
            if (i == 0) begin
                if (qvb !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_lat2_first: q_valid=%b, expected 0", qvb);
                end
            end else if (qvb !== 1'b1 || qb !== vals[i-1]) begin
                failures++;
                $display("FAIL b2b_lat2[%0d]: q=%h q_valid=%b, expected q=%h q_valid=1", i-1, qb, qvb, vals[i-1]);
            end
        end
        @(negedge clk);
        rden = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (qvb !== 1'b0 || qb !== vals[3]) begin
            failures++;
            $display("FAIL b2b_lat2_end: q=%h q_valid=%b, expected q=%h q_valid=0", qb, qvb, vals[3]);
        end
    endtask

    task automatic test_reclear();
        int n;
        int spurious;
        do_write(8'h40, 32'h1111_0000, 4'hF);
        do_read(8'h40, 32'h1111_0000, 32'h1111_0000, "pre_clear");
        @(negedge clk);
        init_req = 1'b1;
        n = 0;
        spurious = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (qva || qvb) spurious++;
            @(negedge clk);
            init_req = (n == 70);
            wren     = (n == 50); wraddr = 8'h40; data = 32'h0000_DEAD; be = 4'hF;
            rden     = (n == 60); rdaddr = 8'h40;
        end while (busya && n < 1000);
        init_req = 1'b0; wren = 1'b0; rden = 1'b0;
        checks++;
        if (n - 1 != 256 || busyb !== 1'b0 || doneb !== 1'b1) begin
            failures++;
            $display("FAIL reclear_len: busy cycles=%0d busy_b=%b done_b=%b, expected 256, 0, 1", n - 1, busyb, doneb);
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL reclear_no_valid: q_valid pulses=%0d, expected 0", spurious);
        end
        do_read(8'h40, INIT_A, INIT_B, "reclear_dropped_write");
        do_read(8'h10, INIT_A, INIT_B, "reclear_10");
    endtask

    task automatic test_reset_mid_clear();
        do_write(8'h50, 32'h0BAD_F00D, 4'hF);
        do_read(8'h50, 32'h0BAD_F00D, 32'h0BAD_F00D, "pre_midreset");
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check_in_reset("midclear_reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        count_clear("midclear_restart");
        do_read(8'h50, INIT_A, INIT_B, "midclear_rd_50");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_byte_enables();
        test_collision();
        test_back_to_back();
        test_reclear();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
